mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//   Single-port RAM controller for the 32-bit core; successor to the combinational memory-control path.
//   Arbitrates between instruction fetch and data (LDR/STR) requests, with a req/done handshake per port.
//   Sequences RAM accesses with a programmable read latency and registers all RAM-side outputs.
//   Muxes load data or ALU result onto a single write-back bus.
// PARAMETERS
//   DATA_W      32     data/instruction word width
//   ADDR_W      16     RAM address width
//   PC_W        8      fetch address width (PC_W <= ADDR_W)
//   RAM_LATENCY 2      cycles from ram_en to valid ram_rdata (>=1)
//   OP_LDR      4'h8   op_code value for load
//   OP_STR      4'h9   op_code value for store
// PORTS
//   clk         in   1       clock, rising edge
//   reset       in   1       synchronous, active-high reset
//   if_req      in   1       fetch request; held until if_valid
//   pc_addr     in   PC_W    fetch address
//   if_valid    out  1       1-cycle pulse: if_instr valid
//   if_instr    out  DATA_W  fetched instruction
//   mem_req     in   1       data-side request; held until mem_done
//   op_code     in   4       operation; LDR/STR access RAM, others pass through
//   src1        in   DATA_W  data address; low ADDR_W bits used
//   src2        in   DATA_W  store data
//   alu_result  in   DATA_W  write-back value for non-memory ops
//   mem_done    out  1       1-cycle pulse: data-side transaction complete
//   wb_data     out  DATA_W  load data (LDR) or alu_result (other ops); held until next mem_done
//   busy        out  1       1 when state != IDLE
//   ram_en      out  1       RAM access strobe, 1 cycle per access
//   ram_we      out  1       write enable, qualified by ram_en
//   ram_addr    out  ADDR_W  RAM address
//   ram_wdata   out  DATA_W  RAM write data
//   ram_rdata   in   DATA_W  RAM read data, valid RAM_LATENCY cycles after ram_en
// BEHAVIOUR
//   - Reset: state=IDLE; all outputs 0; last_grant=FETCH. Reset mid-transaction aborts it.
//     No done/valid pulse is emitted. Late ram_rdata is ignored.
//   - FSM states: IDLE, ACCESS, RESP.
//   - IDLE, accept rule: a request is accepted in a cycle where it is high.
//     Address, op, src2 and alu_result are latched at accept. Later input changes are ignored.
//   - Arbitration: if only one request is pending, grant it.
//     If both are pending, grant the port that was not granted last (alternation, no starvation).
//   - Data, non-memory op: IDLE -> RESP directly. mem_done=1 and wb_data=alu_result in the next cycle (latency 1).
//     No RAM activity.
//   - Data, STR: ACCESS lasts 1 cycle with ram_en=1, ram_we=1, ram_addr=src1[ADDR_W-1:0], ram_wdata=src2.
//     Then RESP with mem_done=1 (latency 2). wb_data is unchanged.
//   - Data, LDR / fetch: ACCESS starts with ram_en=1, ram_we=0 in its first cycle.
//     A down-counter waits RAM_LATENCY cycles; ram_rdata is captured on the RAM_LATENCY-th edge after ram_en.
//     RESP follows with mem_done+wb_data (LDR) or if_valid+if_instr (fetch).
//     Latency from accept cycle to pulse = RAM_LATENCY+2.
//   - Fetch address = zero-extended pc_addr.
//   - ram_en is low outside the first ACCESS cycle. ram_we is 0 whenever ram_en is 0.
//   - RESP lasts 1 cycle, then the FSM returns to IDLE.
//     The requester drops req in the cycle after the pulse. A req still high in IDLE is a new request.
//   - if_instr and wb_data hold their last values between pulses.
// TESTING
//   - Reset during ACCESS of an LDR: no mem_done, busy=0 and ram_en=0 the cycle after reset, outputs 0.
//   - LDR src1=0x0001_0042, RAM_LATENCY=2, ram_rdata=0xDEADBEEF: ram_addr=0x0042, mem_done 4 cycles after accept, wb_data=0xDEADBEEF.
//   - STR src1=0x10, src2=0xCAFEF00D: one ram_en with ram_we=1, ram_addr=0x0010, mem_done 2 cycles after accept.
//   - Non-memory op (op_code=4'h1), alu_result=0x1234: mem_done next cycle, wb_data=0x1234, ram_en stays 0.
//   - if_req and mem_req held high together for 4 transactions: grants alternate (data, fetch, data, fetch given last_grant=FETCH).
//   - Fetch pc_addr=0xFF, RAM_LATENCY=3: ram_addr=0x00FF, if_valid 5 cycles after accept, if_instr=ram_rdata.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Single-port RAM controller: fetch/data arbitration with alternation,
// programmable read latency, registered RAM strobes and a write-back mux.
module mem_access_arbiter #(
  parameter int         DATA_W      = 32,
  parameter int         ADDR_W      = 16,
  parameter int         PC_W        = 8,
  parameter int         RAM_LATENCY = 2,
  parameter logic [3:0] OP_LDR      = 4'h8,
  parameter logic [3:0] OP_STR      = 4'h9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [PC_W-1:0]   pc_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  input  logic              mem_req,
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              mem_done,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(RAM_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_fetch;
  logic             cur_fetch;
  logic             cur_str;
  logic [CNT_W-1:0] cnt;
  logic             grant_fetch;
  logic             grant_data;
  logic             is_ldr;
  logic             is_str;
  logic             data_mem;
  logic             access_done;
  logic             unused_src1;

  assign is_ldr      = (op_code == OP_LDR);
  assign is_str      = (op_code == OP_STR);
  assign data_mem    = is_ldr | is_str;
  assign grant_fetch = if_req & (~mem_req | ~last_fetch);
  assign grant_data  = mem_req & ~grant_fetch;
  assign access_done = cur_str | (cnt == '0);
  assign busy        = (state != IDLE);
  assign unused_src1 = &{1'b0, src1[DATA_W-1:ADDR_W]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: non-memory ops skip ACCESS; loads wait out the latency.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_fetch || (grant_data && data_mem))
          state_nxt = ACCESS;
        else if (grant_data)
          state_nxt = RESP;
      end
      ACCESS: begin
        if (access_done) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accept/latch, RAM strobes, read capture and response pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_fetch <= 1'b1;
      cur_fetch  <= 1'b0;
      cur_str    <= 1'b0;
      cnt        <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      mem_done   <= 1'b0;
      if_valid   <= 1'b0;
      wb_data    <= '0;
      if_instr   <= '0;
    end else begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      mem_done <= 1'b0;
      if_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_fetch || grant_data) begin
            last_fetch <= grant_fetch;
            cur_fetch  <= grant_fetch;
            cur_str    <= grant_data & is_str;
            cnt        <= CNT_W'(RAM_LATENCY);
            if (grant_fetch) begin
              ram_en   <= 1'b1;
              ram_addr <= ADDR_W'(pc_addr);
            end else if (data_mem) begin
              ram_en    <= 1'b1;
              ram_we    <= is_str;
              ram_addr  <= src1[ADDR_W-1:0];
              ram_wdata <= src2;
            end else begin
              mem_done <= 1'b1;
              wb_data  <= alu_result;
            end
          end
        end
        ACCESS: begin
          if (access_done) begin
            if (cur_str) begin
              mem_done <= 1'b1;
            end else if (cur_fetch) begin
              if_valid <= 1'b1;
              if_instr <= ram_rdata;
            end else begin
              mem_done <= 1'b1;
              wb_data  <= ram_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: two instances (read latency 2 and 3),
// transaction-level model checked every cycle plus directed literals.
module tb_mem_access_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req     [2];
  logic [7:0]  pc_addr    [2];
  logic        if_valid   [2];
  logic [31:0] if_instr   [2];
  logic        mem_req    [2];
  logic [3:0]  op_code    [2];
  logic [31:0] src1       [2];
  logic [31:0] src2       [2];
  logic [31:0] alu_result [2];
  logic        mem_done   [2];
  logic [31:0] wb_data    [2];
  logic        busy       [2];
  logic        ram_en     [2];
  logic        ram_we     [2];
  logic [15:0] ram_addr   [2];
  logic [31:0] ram_wdata  [2];
  logic [31:0] ram_rdata  [2];

  int n_pass = 0;
  int n_chk = 0;
  int cyc = 0;

  logic [31:0] mem [2][256];
  int          rd_at   [2];
  logic [7:0]  rd_addr [2];

  // model state
  bit          m_init = 1'b0;
  bit          m_free [2];
  bit          m_lastf[2];
  int          m_k    [2];
  int          m_lat  [2];
  int          m_kind [2];
  logic [15:0] m_addr [2];
  logic [31:0] m_alu  [2];
  bit          e_busy [2];
  bit          e_en   [2];
  bit          e_we   [2];
  bit          e_done [2];
  bit          e_val  [2];
  bit          e_zero [2];
  logic [31:0] e_wb   [2];
  logic [31:0] e_ins  [2];
  logic [31:0] e_wd   [2];
  bit          gf;
  bit          gd;

  always #5 clk = ~clk;

  mem_access_arbiter #(.RAM_LATENCY(2)) u0 (
    .clk(clk), .reset(reset),
    .if_req(if_req[0]), .pc_addr(pc_addr[0]),
    .if_valid(if_valid[0]), .if_instr(if_instr[0]),
    .mem_req(mem_req[0]), .op_code(op_code[0]),
    .src1(src1[0]), .src2(src2[0]),
    .alu_result(alu_result[0]),
    .mem_done(mem_done[0]), .wb_data(wb_data[0]),
    .busy(busy[0]), .ram_en(ram_en[0]),
    .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
    .ram_wdata(ram_wdata[0]),
    .ram_rdata(ram_rdata[0])
  );

  mem_access_arbiter #(.RAM_LATENCY(3)) u1 (
    .clk(clk), .reset(reset),
    .if_req(if_req[1]), .pc_addr(pc_addr[1]),
    .if_valid(if_valid[1]), .if_instr(if_instr[1]),
    .mem_req(mem_req[1]), .op_code(op_code[1]),
    .src1(src1[1]), .src2(src2[1]),
    .alu_result(alu_result[1]),
    .mem_done(mem_done[1]), .wb_data(wb_data[1]),
    .busy(busy[1]), .ram_en(ram_en[1]),
    .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
    .ram_wdata(ram_wdata[1]),
    .ram_rdata(ram_rdata[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h want %h (cyc %0d)",
                  nm, d, act, exp, cyc);
  endtask

  // RAM read data: valid exactly one cycle, RAM_LATENCY cycles after ram_en.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int d = 0; d < 2; d++)
      ram_rdata[d] = (cyc == rd_at[d]) ? mem[d][rd_addr[d]] : JUNK;
  end

  // Compare against model, service RAM, then advance the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_init) begin
        chk("busy", d, 32'(busy[d]), 32'(e_busy[d]));
        chk("ram_en", d, 32'(ram_en[d]), 32'(e_en[d]));
        chk("ram_we", d, 32'(ram_we[d]), 32'(e_we[d]));
        chk("mem_done", d, 32'(mem_done[d]), 32'(e_done[d]));
        chk("if_valid", d, 32'(if_valid[d]), 32'(e_val[d]));
        chk("wb_data", d, wb_data[d], e_wb[d]);
        chk("if_instr", d, if_instr[d], e_ins[d]);
        if (e_en[d])
          chk("ram_addr", d, 32'(ram_addr[d]), 32'(m_addr[d]));
        if (e_we[d])
          chk("ram_wdata", d, ram_wdata[d], e_wd[d]);
        if (e_zero[d]) begin
          chk("rst_addr", d, 32'(ram_addr[d]), 32'h0);
          chk("rst_wdata", d, ram_wdata[d], 32'h0);
        end
      end
      if (ram_en[d] && ram_we[d])
        mem[d][ram_addr[d][7:0]] = ram_wdata[d];
      if (ram_en[d] && !ram_we[d]) begin
        rd_at[d] = cyc + lat_of(d);
        rd_addr[d] = ram_addr[d][7:0];
      end
      if (reset) begin
        m_free[d] = 1'b1;
        m_lastf[d] = 1'b1;
        e_busy[d] = 1'b0;
        e_en[d] = 1'b0;
        e_we[d] = 1'b0;
        e_done[d] = 1'b0;
        e_val[d] = 1'b0;
        e_zero[d] = 1'b1;
        e_wb[d] = '0;
        e_ins[d] = '0;
      end else begin
        e_zero[d] = 1'b0;
        if (m_free[d]) begin
          gf = if_req[d] && (!mem_req[d] || !m_lastf[d]);
          gd = mem_req[d] && !gf;
          if (gf || gd) begin
            m_free[d] = 1'b0;
            m_k[d] = 1;
            m_lastf[d] = gf;
            if (gf) begin
              m_kind[d] = 0;
              m_addr[d] = {8'h00, pc_addr[d]};
              m_lat[d] = lat_of(d) + 2;
            end else if (op_code[d] == 4'h8) begin
              m_kind[d] = 1;
              m_addr[d] = src1[d][15:0];
              m_lat[d] = lat_of(d) + 2;
            end else if (op_code[d] == 4'h9) begin
              m_kind[d] = 2;
              m_addr[d] = src1[d][15:0];
              e_wd[d] = src2[d];
              m_lat[d] = 2;
            end else begin
              m_kind[d] = 3;
              m_alu[d] = alu_result[d];
              m_lat[d] = 1;
            end
          end
        end else if (m_k[d] == m_lat[d]) begin
          m_free[d] = 1'b1;
        end else begin
          m_k[d]++;
        end
        e_busy[d] = !m_free[d];
        e_en[d] = !m_free[d] && m_k[d] == 1 && m_kind[d] != 3;
        e_we[d] = e_en[d] && m_kind[d] == 2;
        e_done[d] = !m_free[d] && m_k[d] == m_lat[d]
                    && m_kind[d] != 0;
        e_val[d] = !m_free[d] && m_k[d] == m_lat[d]
                   && m_kind[d] == 0;
        if (e_done[d] && m_kind[d] == 1)
          e_wb[d] = mem[d][m_addr[d][7:0]];
        if (e_done[d] && m_kind[d] == 3)
          e_wb[d] = m_alu[d];
        if (e_val[d])
          e_ins[d] = mem[d][m_addr[d][7:0]];
      end
    end
    if (reset) m_init = 1'b1;
  end

  // One request from one port; reports latency and what the RAM saw.
  task automatic txn(input int d, input bit fetch,
                     input logic [3:0] op,
                     input logic [31:0] s1,
                     input logic [31:0] s2,
                     input logic [31:0] alu,
                     input logic [7:0] pc,
                     output int lat_c, output int en_n,
                     output logic [15:0] addr_seen,
                     output bit we_seen,
                     output logic [31:0] data_seen);
    int  a;
    bit  got;
    got = 1'b0;
    lat_c = -1;
    en_n = 0;
    addr_seen = '0;
    we_seen = 1'b0;
    data_seen = '0;
    @(posedge clk);
    #1;
    op_code[d] = op;
    src1[d] = s1;
    src2[d] = s2;
    alu_result[d] = alu;
    pc_addr[d] = pc;
    if (fetch) if_req[d] = 1'b1;
    else       mem_req[d] = 1'b1;
    a = cyc;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ram_en[d]) begin
        en_n++;
        addr_seen = ram_addr[d];
        we_seen = ram_we[d];
      end
      if (fetch ? if_valid[d] : mem_done[d]) begin
        lat_c = cyc - a;
        data_seen = fetch ? if_instr[d] : wb_data[d];
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (i == 0) begin
        op_code[d] = 4'h1;
        src1[d] = 32'hFFFF_FFF0;
        src2[d] = 32'h0BAD_0BAD;
        alu_result[d] = 32'hEEEE_EEEE;
        pc_addr[d] = 8'h33;
      end
    end
    chk("pulse_seen", d, 32'(got), 32'h1);
    @(posedge clk);
    #1;
    if_req[d] = 1'b0;
    mem_req[d] = 1'b0;
  endtask

  int          lat_c;
  int          en_n;
  logic [15:0] addr_s;
  bit          we_s;
  logic [31:0] dat_s;
  int          code;
  int          npulse;

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++)
        mem[d][i] = {8'(d + 1), 8'(i), 8'hC3, ~8'(i)};
      if_req[d] = 1'b0;
      mem_req[d] = 1'b0;
      pc_addr[d] = '0;
      op_code[d] = '0;
      src1[d] = '0;
      src2[d] = '0;
      alu_result[d] = '0;
      ram_rdata[d] = JUNK;
      rd_at[d] = -1;
      rd_addr[d] = '0;
    end
    mem[0][8'h42] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_state", d,
          {26'h0, busy[d], ram_en[d], ram_we[d], mem_done[d],
           if_valid[d], 1'b0}, 32'h0);
      chk("rst_wb", d, wb_data[d] | if_instr[d], 32'h0);
    end

    txn(0, 0, 4'h1, 32'h0, 32'h0, 32'h1234, 8'h0,
        lat_c, en_n, addr_s, we_s, dat_s);
    chk("alu_lat", 0, 32'(lat_c), 32'd1);
    chk("alu_no_ram", 0, 32'(en_n), 32'd0);
    chk("alu_wb", 0, dat_s, 32'h1234);

    txn(0, 0, 4'h9, 32'h10, 32'hCAFE_F00D, 32'h0, 8'h0,
        lat_c, en_n, addr_s, we_s, dat_s);
    chk("str_lat", 0, 32'(lat_c), 32'd2);
    chk("str_en_n", 0, 32'(en_n), 32'd1);
    chk("str_addr", 0, 32'(addr_s), 32'h10);
    chk("str_we", 0, 32'(we_s), 32'h1);
    chk("str_wb_hold", 0, dat_s, 32'h1234);
    chk("str_mem", 0, mem[0][8'h10], 32'hCAFE_F00D);

    txn(0, 0, 4'h8, 32'h0001_0042, 32'h0, 32'h0, 8'h0,
        lat_c, en_n, addr_s, we_s, dat_s);
    chk("ldr_lat", 0, 32'(lat_c), 32'd4);
    chk("ldr_addr", 0, 32'(addr_s), 32'h0042);
    chk("ldr_we", 0, 32'(we_s), 32'h0);
    chk("ldr_wb", 0, dat_s, 32'hDEAD_BEEF);

    txn(0, 0, 4'h8, 32'h10, 32'h0, 32'h0, 8'h0,
        lat_c, en_n, addr_s, we_s, dat_s);
    chk("ldr_back", 0, dat_s, 32'hCAFE_F00D);

    txn(0, 1, 4'h0, 32'h0, 32'h0, 32'h0, 8'h80,
        lat_c, en_n, addr_s, we_s, dat_s);
    chk("if_lat", 0, 32'(lat_c), 32'd4);
    chk("if_addr", 0, 32'(addr_s), 32'h0080);
    chk("if_instr", 0, dat_s, 32'h0180_C37F);

    // reset while an LDR is in ACCESS
    @(posedge clk);
    #1;
    op_code[0] = 4'h8;
    src1[0] = 32'h30;
    mem_req[0] = 1'b1;
    @(posedge clk);
    #1;
    mem_req[0] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 0, 32'(busy[0]), 32'h0);
    chk("abort_en", 0, 32'(ram_en[0]), 32'h0);
    chk("abort_wb", 0, wb_data[0], 32'h0);
    chk("abort_ins", 0, if_instr[0], 32'h0);
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_done[0] || if_valid[0]) npulse++;
      @(negedge clk);
    end
    chk("abort_no_done", 0, 32'(npulse), 32'h0);

    // both ports held: grants must alternate starting with data
    @(posedge clk);
    #1;
    op_code[0] = 4'h9;
    src1[0] = 32'h20;
    src2[0] = 32'h5555_AAAA;
    pc_addr[0] = 8'h05;
    mem_req[0] = 1'b1;
    if_req[0] = 1'b1;
    code = 0;
    npulse = 0;
    for (int i = 0; i < 60 && npulse < 4; i++) begin
      @(negedge clk);
      if (mem_done[0]) begin
        code = code * 2;
        npulse++;
      end else if (if_valid[0]) begin
        code = code * 2 + 1;
        npulse++;
      end
    end
    @(posedge clk);
    #1;
    mem_req[0] = 1'b0;
    if_req[0] = 1'b0;
    chk("arb_count", 0, 32'(npulse), 32'd4);
    chk("arb_order", 0, 32'(code), 32'b0101);

    txn(1, 1, 4'h0, 32'h0, 32'h0, 32'h0, 8'hFF,
        lat_c, en_n, addr_s, we_s, dat_s);
    chk("if3_lat", 1, 32'(lat_c), 32'd5);
    chk("if3_addr", 1, 32'(addr_s), 32'h00FF);
    chk("if3_en_n", 1, 32'(en_n), 32'd1);
    chk("if3_instr", 1, dat_s, 32'h02FF_C300);

    txn(1, 0, 4'h8, 32'h0000_0042, 32'h0, 32'h0, 8'h0,
        lat_c, en_n, addr_s, we_s, dat_s);
    chk("ldr3_lat", 1, 32'(lat_c), 32'd5);
    chk("ldr3_wb", 1, dat_s, 32'h0242_C3BD);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
